// File: rtl/conv_pkg.sv
// Shared types and constants for the convolver AIP sequencer.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } conv_state_e;

    // confReg field layout
    localparam int unsigned SIZE_X_LSB   = 1;
    localparam int unsigned SIZE_Y_LSB   = 6;
    localparam int unsigned SIZEW        = 5;

    // STATUS register bit latched from done
    localparam int unsigned INT_BIT_DONE = 0;

    // memX / memY / memZ depth
    localparam int unsigned MEM_DEPTH    = 64;

endpackage

// File: rtl/conv_mac.sv
// Registered multiply-accumulate; keeps only the low DATAWIDTH bits of each product.
module conv_mac #(
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_a,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 acc_en,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] acc
);

    logic [DATAWIDTH-1:0] acc_q;
    logic [DATAWIDTH-1:0] acc_d;

    // Next accumulator value: clear wins, otherwise add the truncated product
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + a * b;
        end
    end

    // Accumulator register, frozen while en is low
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/conv_sequencer.sv
// 1-D convolution sequencer: walks n and k, issues memX/memY reads, accumulates, writes memZ.
module conv_sequencer #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned ADDRW     = 6,
    parameter int unsigned SIZEW     = 5
) (
    input  logic                 clk,
    input  logic                 rst_a,
    input  logic                 en_s,
    input  logic                 start,
    input  logic [SIZEW-1:0]     size_x,
    input  logic [SIZEW-1:0]     size_y,
    output logic [ADDRW-1:0]     x_addr,
    input  logic [DATAWIDTH-1:0] x_data,
    output logic [ADDRW-1:0]     y_addr,
    input  logic [DATAWIDTH-1:0] y_data,
    output logic [ADDRW-1:0]     z_addr,
    output logic [DATAWIDTH-1:0] z_data,
    output logic                 z_we,
    output logic                 busy,
    output logic                 done
);

    import conv_pkg::*;

    conv_state_e          state_q, state_d;
    logic [SIZEW-1:0]     lx_q, lx_d;
    logic [SIZEW-1:0]     ly_q, ly_d;
    logic [ADDRW-1:0]     n_q, n_d;
    logic [ADDRW-1:0]     k_q, k_d;
    logic [ADDRW-1:0]     kmax_q, kmax_d;
    logic [ADDRW-1:0]     x_addr_q, x_addr_d;
    logic [ADDRW-1:0]     y_addr_q, y_addr_d;
    logic [ADDRW-1:0]     z_addr_q, z_addr_d;
    logic                 z_we_q, z_we_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 acc_en_q, acc_en_d;
    logic                 mac_clr_c;
    logic [ADDRW-1:0]     kmin_c;
    logic [ADDRW-1:0]     kmax_c;
    logic [ADDRW-1:0]     last_n_c;

    // Summation bounds for the current output index n
    always_comb begin
        kmin_c   = '0;
        if ((n_q + ADDRW'(1)) > ADDRW'(ly_q)) begin
            kmin_c = n_q + ADDRW'(1) - ADDRW'(ly_q);
        end
        kmax_c   = (n_q < ADDRW'(lx_q)) ? n_q : (ADDRW'(lx_q) - ADDRW'(1));
        last_n_c = ADDRW'(lx_q) + ADDRW'(ly_q) - ADDRW'(2);
    end

    // Next-state, counters and registered-output decode
    always_comb begin
        state_d   = state_q;
        lx_d      = lx_q;
        ly_d      = ly_q;
        n_d       = n_q;
        k_d       = k_q;
        kmax_d    = kmax_q;
        x_addr_d  = x_addr_q;
        y_addr_d  = y_addr_q;
        z_addr_d  = z_addr_q;
        mac_clr_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((size_x != '0) && (size_y != '0)) begin
                        state_d = SETUP;
                        lx_d    = size_x;
                        ly_d    = size_y;
                        n_d     = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SETUP: begin
                mac_clr_c = 1'b1;
                k_d       = kmin_c;
                kmax_d    = kmax_c;
                x_addr_d  = kmin_c;
                y_addr_d  = n_q - kmin_c;
                state_d   = ISSUE;
            end
            ISSUE: begin
                if (k_q == kmax_q) begin
                    state_d = DRAIN;
                end else begin
                    k_d      = k_q + ADDRW'(1);
                    x_addr_d = k_d;
                    y_addr_d = n_q - k_d;
                end
            end
            DRAIN: begin
                z_addr_d = n_q;
                state_d  = WRITE;
            end
            WRITE: begin
                if (n_q == last_n_c) begin
                    state_d = DONE;
                end else begin
                    n_d     = n_q + ADDRW'(1);
                    state_d = SETUP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d   = state_d inside {SETUP, ISSUE, DRAIN, WRITE};
        z_we_d   = (state_d == WRITE);
        // read data arrives the cycle after each issued address
        acc_en_d = (state_q == ISSUE);
        // pulse on entry to DONE after a run; a zero-length run pulses on leaving DONE
        done_d   = ((state_q == WRITE) && (state_d == DONE)) ||
                   ((state_q == DONE) && !done_q);
    end

    // State, counters and registered outputs; everything holds while en_s is low
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q  <= IDLE;
            lx_q     <= '0;
            ly_q     <= '0;
            n_q      <= '0;
            k_q      <= '0;
            kmax_q   <= '0;
            x_addr_q <= '0;
            y_addr_q <= '0;
            z_addr_q <= '0;
            z_we_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_en_q <= 1'b0;
        end else if (en_s) begin
            state_q  <= state_d;
            lx_q     <= lx_d;
            ly_q     <= ly_d;
            n_q      <= n_d;
            k_q      <= k_d;
            kmax_q   <= kmax_d;
            x_addr_q <= x_addr_d;
            y_addr_q <= y_addr_d;
            z_addr_q <= z_addr_d;
            z_we_q   <= z_we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            acc_en_q <= acc_en_d;
        end
    end

    conv_mac #(
        .DATAWIDTH(DATAWIDTH)
    ) u_mac (
        .clk    (clk),
        .rst_a  (rst_a),
        .en     (en_s),
        .clr    (mac_clr_c),
        .acc_en (acc_en_q),
        .a      (x_data),
        .b      (y_data),
        .acc    (z_data)
    );

    assign x_addr = x_addr_q;
    assign y_addr = y_addr_q;
    assign z_addr = z_addr_q;
    assign z_we   = z_we_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer with behavioural memX/memY/memZ and a STATUS latch.
module tb_conv_sequencer;

    import conv_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 6;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } zexp_t;

    logic           clk    = 1'b0;
    logic           rst_a  = 1'b0;
    logic           en_s   = 1'b1;
    logic           start  = 1'b0;
    logic [SIZEW-1:0] size_x = '0;
    logic [SIZEW-1:0] size_y = '0;
    logic [AW-1:0]  x_addr, y_addr, z_addr;
    logic [DW-1:0]  x_data = '0;
    logic [DW-1:0]  y_data = '0;
    logic [DW-1:0]  z_data;
    logic           z_we, busy, done;

    logic [DW-1:0]  memx [MEM_DEPTH];
    logic [DW-1:0]  memy [MEM_DEPTH];
    logic [DW-1:0]  memz [MEM_DEPTH];
    logic [31:0]    status;
    logic           clr_status = 1'b0;
    logic           int_req;

    zexp_t          zq[$];
    int             doneq[$];
    int             edge_cnt = 0;
    int             checks = 0;
    int             errors = 0;
    logic           busy_seen = 1'b0;

    conv_sequencer dut (
        .clk    (clk),
        .rst_a  (rst_a),
        .en_s   (en_s),
        .start  (start),
        .size_x (size_x),
        .size_y (size_y),
        .x_addr (x_addr),
        .x_data (x_data),
        .y_addr (y_addr),
        .y_data (y_data),
        .z_addr (z_addr),
        .z_data (z_data),
        .z_we   (z_we),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // memories share the en_s gate with the sequencer
    always @(posedge clk) begin
        if (en_s) begin
            x_data <= memx[x_addr];
            y_data <= memy[y_addr];
            if (z_we) memz[z_addr] <= z_data;
        end
    end

    // wrapper STATUS latch feeding int_req
    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) status <= '0;
        else if (clr_status) status <= '0;
        else if (en_s && done) status[INT_BIT_DONE] <= 1'b1;
    end
    assign int_req = status[INT_BIT_DONE];

    // monitor: pop and compare on every committed write and every done pulse
    always @(negedge clk) begin : monitor
        zexp_t e;
        int    de;
        if (rst_a && en_s) begin
            if (busy) busy_seen = 1'b1;
            if (z_we) begin
                checks++;
                if (zq.size() == 0) begin
                    errors++;
                    $display("FAIL z_write unexpected: got addr=%0d data=%h, expected no write", z_addr, z_data);
                end else begin
                    e = zq.pop_front();
                    if (z_addr !== e.addr || z_data !== e.data) begin
                        errors++;
                        $display("FAIL z_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 z_addr, z_data, e.addr, e.data);
                    end
                end
            end
            if (done) begin
                checks++;
                if (doneq.size() == 0) begin
                    errors++;
                    $display("FAIL done unexpected at edge %0d", edge_cnt);
                end else begin
                    de = doneq.pop_front();
                    if (edge_cnt != de || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL done_timing: got edge=%0d busy=%0b, expected edge=%0d busy=0",
                                 edge_cnt, busy, de);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic push_basic();
        // x=[1,2,3], y=[1,1] -> z=[1,3,5,3]
        zq.push_back({AW'(0), 32'd1});
        zq.push_back({AW'(1), 32'd3});
        zq.push_back({AW'(2), 32'd5});
        zq.push_back({AW'(3), 32'd3});
    endtask

    task automatic push_ref(input int lx, input int ly, input int cnt);
        logic [DW-1:0] s;
        for (int n = 0; n < cnt; n++) begin
            s = '0;
            for (int k = 0; k < lx; k++) begin
                if ((n - k) >= 0 && (n - k) < ly) s = s + memx[k] * memy[n - k];
            end
            zq.push_back({AW'(n), s});
        end
    endtask

    // mode: 0 plain, 1 start/confReg disturbed, 2 en_s stall, 3 reset during output-5 WRITE
    task automatic run(input int lx, input int ly, input int mode);
        logic [31:0] conf;
        int          dly;
        @(negedge clk);
        dly = (lx == 0 || ly == 0) ? 1 : lx * ly + 3 * (lx + ly - 1);
        if (mode == 2) dly += 7;
        if (mode != 3) doneq.push_back(edge_cnt + 1 + dly);
        conf = '0;
        conf[SIZE_X_LSB +: SIZEW] = SIZEW'(lx);
        conf[SIZE_Y_LSB +: SIZEW] = SIZEW'(ly);
        size_x = conf[SIZE_X_LSB +: SIZEW];
        size_y = conf[SIZE_Y_LSB +: SIZEW];
        busy_seen = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        case (mode)
            1: begin
                repeat (4) @(posedge clk);
                #1 start = 1'b1; size_x = 5'd7; size_y = 5'd7;
                repeat (3) @(posedge clk);
                #1 start = 1'b0; size_x = 5'd0; size_y = 5'd9;
            end
            2: begin
                repeat (6) @(posedge clk);
                #1 en_s = 1'b0;
                repeat (7) @(posedge clk);
                #1 en_s = 1'b1;
            end
            3: begin
                repeat (37) @(posedge clk);
                #1 chk("abort_point_write5", 64'({z_we, z_addr}), 64'({1'b1, AW'(5)}));
                #1 rst_a = 1'b0;
                #1 chk("abort_outputs_zero", 64'({x_addr, y_addr, z_addr, z_data, z_we, busy, done}), 64'd0);
                chk("abort_state_idle", 64'(dut.state_q), 64'(IDLE));
                repeat (2) @(posedge clk);
                #1 rst_a = 1'b1;
            end
            default: ;
        endcase
        for (int i = 0; i < 600; i++) begin
            if (zq.size() == 0 && doneq.size() == 0) break;
            @(negedge clk);
            #1;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (zq.size() != 0 || doneq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d writes and %0d done left pending, expected 0 and 0",
                     zq.size(), doneq.size());
            zq.delete();
            doneq.delete();
        end
        chk("busy_seen", 64'(busy_seen), 64'((lx != 0 && ly != 0) ? 1 : 0));
    endtask

    initial begin
        for (int i = 0; i < int'(MEM_DEPTH); i++) begin
            memx[i] = '0;
            memy[i] = '0;
            memz[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", 64'({x_addr, y_addr, z_addr, z_data, z_we, busy, done}), 64'd0);
        rst_a = 1'b1;

        // basic
        memx[0] = 32'd1; memx[1] = 32'd2; memx[2] = 32'd3;
        memy[0] = 32'd1; memy[1] = 32'd1;
        push_basic();
        run(3, 2, 0);
        chk("basic_memz3", 64'(memz[3]), 64'd3);

        // start re-pulse and confReg change mid-run
        push_basic();
        run(3, 2, 1);

        // seven-cycle stall during ISSUE
        push_basic();
        run(3, 2, 2);

        // wrap of a single product
        memx[0] = 32'hFFFF_FFFF; memy[0] = 32'd2;
        zq.push_back({AW'(0), 32'hFFFF_FFFE});
        run(1, 1, 0);

        // zero length: done only, no writes, no busy
        run(0, 5, 0);

        // full 10x5 case and interrupt latch
        for (int i = 0; i < 10; i++) memx[i] = DW'($urandom_range(0, 99));
        for (int i = 0; i < 5; i++)  memy[i] = DW'($urandom_range(0, 99));
        @(negedge clk); clr_status = 1'b1;
        @(negedge clk); clr_status = 1'b0;
        chk("int_req_cleared", 64'(int_req), 64'd0);
        push_ref(10, 5, 14);
        run(10, 5, 0);
        chk("int_req_after_done", 64'(int_req), 64'd1);

        // reset during output-5 WRITE, then a fresh run
        push_ref(10, 5, 5);
        run(10, 5, 3);
        push_ref(10, 5, 14);
        run(10, 5, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Sequencer for the 1-D convolution datapath inside the convolver AIP core. It runs z[n] = Σ x[k]·y[n−k] over memX (length size_x) and memY (length size_y). It issues the read addresses, accumulates products and writes each result into memZ. It raises a one-cycle `done` that the AIP wrapper latches into STATUS bit 0 (INT_BIT_DONE) for `int_req`.

## Interface
- DATAWIDTH, 32, data and accumulator width
- ADDRW, 6, memory address width (depth 64)
- SIZEW, 5, width of the size fields from confReg
- clk  in  1  clock, rising edge
- rst_a  in  1  asynchronous, active-low reset
- en_s  in  1  synchronous enable; low freezes all state and outputs
- start  in  1  start pulse from the AIP start line
- size_x  in  SIZEW  X length, confReg[5:1]
- size_y  in  SIZEW  Y length, confReg[10:6]
- x_addr  out  ADDRW  memX read address
- x_data  in  DATAWIDTH  memX read data, valid one cycle after x_addr
- y_addr  out  ADDRW  memY read address
- y_data  in  DATAWIDTH  memY read data, valid one cycle after y_addr
- z_addr  out  ADDRW  memZ write address
- z_data  out  DATAWIDTH  memZ write data
- z_we  out  1  memZ write strobe
- busy  out  1  high from the SETUP state through the WRITE state
- done  out  1  one-cycle completion pulse

## Operation
- Reset drives every output to 0 and the FSM to IDLE. The accumulator and counters clear.
- States:
  - IDLE: waits for start.
  - SETUP: computes kmin = max(0, n−Ly+1) and kmax = min(n, Lx−1), sets k = kmin and clears the accumulator.
  - ISSUE: drives x_addr = k and y_addr = n−k for k = kmin..kmax, one address per cycle.
  - DRAIN: performs the final accumulate.
  - WRITE: drives z_we = 1, z_addr = n, z_data = acc.
  - DONE: pulses done.
- Transitions:
  - IDLE→SETUP when start=1 with both sizes nonzero. size_x and size_y are latched as Lx and Ly, and n = 0.
  - IDLE→DONE when start=1 and either size is 0. Nothing is written.
  - SETUP→ISSUE.
  - ISSUE→DRAIN after the k = kmax cycle.
  - DRAIN→WRITE.
  - WRITE→SETUP with n+1 if n < Lx+Ly−2. Otherwise WRITE→DONE.
  - DONE→IDLE.
- Accumulate: acc ← acc + (x_data·y_data)[DATAWIDTH−1:0] in the cycle after each issued address. The sum wraps modulo 2^DATAWIDTH and the operands are unsigned.
- Output count is Lx+Ly−1, at most 61. This always fits in ADDRW.
- start is ignored outside IDLE. The latched sizes are immune to confReg changes during a run.
- When en_s=0, the FSM, counters and accumulator hold, and outputs hold their values. A read issued before the stall has its data consumed only in the first enabled cycle after the stall. The memories are also gated by en_s, so the data is stable.
- rst_a asserted mid-run aborts immediately to the reset state. memZ may hold a partial result and no done is produced.

## Timing
- Let start be sampled at edge 0. The first SETUP cycle follows edge 0.
- Output n takes L_n + 3 cycles, where L_n = kmax − kmin + 1.
- done is high for exactly the cycle following edge Lx·Ly + 3·(Lx+Ly−1). Example: Lx=10, Ly=5 gives edge 92.
- For a zero size, done is high for the cycle following edge 1.
- z_we is high for exactly one cycle per output. The write commits at the edge that ends WRITE.
- busy falls in the same cycle that done rises.
- x_addr and y_addr hold their last values outside ISSUE.

## Structure
- Shared package conv_pkg holds:
  - the state enum (IDLE, SETUP, ISSUE, DRAIN, WRITE, DONE);
  - confReg field constants SIZE_X_LSB=1, SIZE_Y_LSB=6, SIZEW=5;
  - the STATUS bit INT_BIT_DONE=0;
  - the memory depth constant 64.
- One sub-module, conv_mac: a registered multiply-accumulate with clear, enable and DATAWIDTH truncation.
- The FSM, index counters and bounds logic live in conv_sequencer.

## Test plan
- Basic: x=[1,2,3], y=[1,1] → z writes [1,3,5,3] at addresses 0..3, done at edge 3·2+3·4=18, 4 z_we pulses.
- Full case: size_x=10, size_y=5 with random data <100 → 14 outputs match a reference model, done at edge 92, then int_req asserts via the wrapper.
- Zero length: size_x=0, size_y=5 → no z_we, done pulse at edge 1, busy never high.
- Wrap: x=[0xFFFFFFFF], y=[2] → z[0]=0xFFFFFFFE, done at edge 4.
- Robustness:
  - start re-pulsed mid-run and confReg changed mid-run → results unchanged.
  - en_s low for 7 cycles during ISSUE → results correct and done delayed by exactly 7 cycles.
- Reset: rst_a low during the output-5 WRITE state → all outputs 0 asynchronously, FSM in IDLE, no done. A fresh start then completes correctly.
